// File: rtl/torrence_types.sv
// Shared memory-system types: L1/L2 request encodings, requester ids and
// the L2 port scheduler state encoding.
package torrence_types;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } memory_operation_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_access_size_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_id_t;

  // Plain vector encoding keeps the state compatible with older tooling.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE     = 2'd0;
  localparam arb_state_t ISSUE    = 2'd1;
  localparam arb_state_t WAIT_RSP = 2'd2;
  localparam arb_state_t RESPOND  = 2'd3;

  function automatic requester_id_t other_requester(input requester_id_t id);
    return (id == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
  import torrence_types::*;
(
  input  logic          icache_valid,
  input  logic          dcache_valid,
  input  requester_id_t last_grant,
  output logic          grant_valid,
  output requester_id_t grant_id
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = icache_valid | dcache_valid;
    grant_id    = ICACHE;
    if (icache_valid && dcache_valid) begin
      grant_id = other_requester(last_grant);
    end else if (dcache_valid) begin
      grant_id = DCACHE;
    end
  end

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares the blocking L2 request port between the icache and dcache miss paths,
// one transaction at a time. Define L2_SCHED_PERF_CNT_EN to add grant/contention counters.
module l2_port_scheduler
  import torrence_types::*;
#(
  parameter int XLEN = 32
`ifdef L2_SCHED_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                icache_req_valid,
  input  logic [XLEN-1:0]     icache_req_addr,
  output logic                icache_req_ready,
  output logic                icache_rsp_valid,
  output logic [XLEN-1:0]     icache_rsp_rdata,

  input  logic                dcache_req_valid,
  input  memory_operation_t   dcache_req_op,
  input  memory_access_size_t dcache_req_size,
  input  logic [XLEN-1:0]     dcache_req_addr,
  input  logic [XLEN-1:0]     dcache_req_wdata,
  output logic                dcache_req_ready,
  output logic                dcache_rsp_valid,
  output logic [XLEN-1:0]     dcache_rsp_rdata,

  output logic                l2_req_valid,
  output memory_operation_t   l2_req_op,
  output memory_access_size_t l2_req_size,
  output logic [XLEN-1:0]     l2_req_addr,
  output logic [XLEN-1:0]     l2_req_wdata,
  input  logic                l2_req_ready,
  input  logic                l2_rsp_valid,
  input  logic [XLEN-1:0]     l2_rsp_rdata
`ifdef L2_SCHED_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] icache_grant_count,
  output logic [CNT_WIDTH-1:0] dcache_grant_count,
  output logic [CNT_WIDTH-1:0] contention_cycles
`endif
);

  arb_state_t          state_q;
  requester_id_t       owner_q;
  requester_id_t       last_grant_q;
  memory_operation_t   hold_op_q;
  memory_access_size_t hold_size_q;
  logic [XLEN-1:0]     hold_addr_q;
  logic [XLEN-1:0]     hold_wdata_q;
  logic [XLEN-1:0]     rsp_rdata_q;
  logic                icache_ready_q;
  logic                dcache_ready_q;

  logic                grant_valid;
  requester_id_t       grant_id;

  rr_pick2 u_pick (
    .icache_valid (icache_req_valid),
    .dcache_valid (dcache_req_valid),
    .last_grant   (last_grant_q),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= ICACHE;
      last_grant_q   <= DCACHE;
      hold_op_q      <= READ;
      hold_size_q    <= BYTE;
      hold_addr_q    <= '0;
      hold_wdata_q   <= '0;
      rsp_rdata_q    <= '0;
      icache_ready_q <= 1'b0;
      dcache_ready_q <= 1'b0;
    end else begin
      icache_ready_q <= 1'b0;
      dcache_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_id;
            state_q <= ISSUE;
            if (grant_id == ICACHE) begin
              // The icache only ever fetches whole words.
              hold_op_q      <= READ;
              hold_size_q    <= WORD;
              hold_addr_q    <= icache_req_addr;
              hold_wdata_q   <= '0;
              icache_ready_q <= 1'b1;
            end else begin
              hold_op_q      <= dcache_req_op;
              hold_size_q    <= dcache_req_size;
              hold_addr_q    <= dcache_req_addr;
              hold_wdata_q   <= dcache_req_wdata;
              dcache_ready_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (l2_req_ready) begin
            // A response arriving with the accept skips the wait state.
            if (l2_rsp_valid) begin
              rsp_rdata_q <= l2_rsp_rdata;
              state_q     <= RESPOND;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (l2_rsp_valid) begin
            rsp_rdata_q <= l2_rsp_rdata;
            state_q     <= RESPOND;
          end
        end
        RESPOND: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign icache_req_ready = icache_ready_q;
  assign dcache_req_ready = dcache_ready_q;
  assign icache_rsp_valid = (state_q == RESPOND) && (owner_q == ICACHE);
  assign dcache_rsp_valid = (state_q == RESPOND) && (owner_q == DCACHE);
  assign icache_rsp_rdata = rsp_rdata_q;
  assign dcache_rsp_rdata = rsp_rdata_q;

  assign l2_req_valid = (state_q == ISSUE);
  assign l2_req_op    = hold_op_q;
  assign l2_req_size  = hold_size_q;
  assign l2_req_addr  = hold_addr_q;
  assign l2_req_wdata = hold_wdata_q;

`ifdef L2_SCHED_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] icache_cnt_q;
  logic [CNT_WIDTH-1:0] dcache_cnt_q;
  logic [CNT_WIDTH-1:0] contention_q;
  logic                 idle_grant;
  logic                 idle_contention;

  assign idle_grant      = (state_q == IDLE) && grant_valid;
  assign idle_contention = (state_q == IDLE) && icache_req_valid && dcache_req_valid;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      icache_cnt_q <= '0;
      dcache_cnt_q <= '0;
      contention_q <= '0;
    end else begin
      if (idle_grant && (grant_id == ICACHE) && (icache_cnt_q != CNT_MAX))
        icache_cnt_q <= icache_cnt_q + CNT_WIDTH'(1);
      if (idle_grant && (grant_id == DCACHE) && (dcache_cnt_q != CNT_MAX))
        dcache_cnt_q <= dcache_cnt_q + CNT_WIDTH'(1);
      if (idle_contention && (contention_q != CNT_MAX))
        contention_q <= contention_q + CNT_WIDTH'(1);
    end
  end

  assign icache_grant_count = icache_cnt_q;
  assign dcache_grant_count = dcache_cnt_q;
  assign contention_cycles  = contention_q;
`endif

  // A response with no transaction waiting on it points at an L2 protocol bug.
  spurious_l2_rsp: assert property (@(posedge clk) disable iff (!reset)
    !(l2_rsp_valid && ((state_q == IDLE) || (state_q == RESPOND))));

endmodule
